// File: rtl/l1_mshr_miss_ctrl.sv
// Non-blocking L1 miss controller: N_MSHR outstanding-miss entries, secondary-miss merging,
// dirty-victim writeback ahead of the line read, tagged L2 requests and out-of-order fills.
module l1_mshr_miss_ctrl #(
  parameter int LINE_W     = 26,
  parameter int N_MSHR     = 4,
  parameter int MERGE_W    = 2,
  parameter int L2_CLK_DIV = 1,
  localparam int ID_W      = $clog2(N_MSHR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               miss_valid,
  input  logic [LINE_W-1:0]  miss_line,
  input  logic               miss_dirty,
  input  logic [LINE_W-1:0]  miss_victim,
  output logic               miss_ready,
  output logic               proc_stall,
  output logic               wb_rd_en,
  output logic               l2_req_valid,
  output logic               l2_req_rw,
  output logic [LINE_W-1:0]  l2_req_line,
  output logic [ID_W-1:0]    l2_req_id,
  input  logic               l2_stall,
  input  logic               l2_resp_valid,
  input  logic [ID_W-1:0]    l2_resp_id,
  output logic               fill_valid,
  output logic [LINE_W-1:0]  fill_line,
  output logic [ID_W-1:0]    fill_id,
  output logic [MERGE_W-1:0] fill_merges,
  input  logic               fill_ready,
  output logic [ID_W:0]      mshr_count,
  output logic               protocol_err
);

  localparam int HOLD_CYC = 2 * L2_CLK_DIV;
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [ID_W:0] CNT_ONE = (ID_W + 1)'(1);

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_ISSUED, E_DONE} entry_state_t;
  typedef enum logic [1:0] {S_IDLE, S_WB_HOLD, S_WB_REQ, S_RD_REQ} issue_state_t;

  entry_state_t               ent_state  [N_MSHR];
  logic [LINE_W-1:0]          ent_line   [N_MSHR];
  logic [LINE_W-1:0]          ent_victim [N_MSHR];
  logic                       ent_wb     [N_MSHR];
  logic [MERGE_W-1:0]         ent_merges [N_MSHR];

  issue_state_t               iss_state;
  logic [ID_W-1:0]            cur_id;
  logic [HOLD_W-1:0]          hold_cnt;
  logic                       fill_lock;
  logic [ID_W-1:0]            fill_sel;

  logic                       hit_found, free_found, pend_found, done_found;
  logic [ID_W-1:0]            hit_idx, free_idx, pend_idx, done_idx;
  logic                       fill_hs, merge_ok, do_merge, do_alloc, rd_accept, wb_accept;

  // Lowest-index search: iterating downward lets the lowest match win.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (ent_state[i] != E_FREE && ent_line[i] == miss_line) begin
        hit_found = 1'b1;
        hit_idx   = ID_W'(i);
      end
      if (ent_state[i] == E_FREE) begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end
      if (ent_state[i] == E_PENDING) begin
        pend_found = 1'b1;
        pend_idx   = ID_W'(i);
      end
      if (ent_state[i] == E_DONE) begin
        done_found = 1'b1;
        done_idx   = ID_W'(i);
      end
    end
  end

  // A fill once offered stays on the same entry until L1 takes it.
  always_comb begin
    fill_valid  = fill_lock | done_found;
    fill_id     = fill_lock ? fill_sel : done_idx;
    fill_line   = ent_line[fill_id];
    fill_merges = ent_merges[fill_id];
    fill_hs     = fill_valid & fill_ready;
    merge_ok    = hit_found && (ent_merges[hit_idx] != '1) && !(fill_hs && fill_id == hit_idx);
    miss_ready  = ~reset & (hit_found ? merge_ok : free_found);
    proc_stall  = miss_valid & ~miss_ready;
    do_merge    = miss_valid & miss_ready & hit_found;
    do_alloc    = miss_valid & miss_ready & ~hit_found;
    rd_accept   = (iss_state == S_RD_REQ) & ~l2_stall;
    wb_accept   = (iss_state == S_WB_REQ) & ~l2_stall;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_MSHR; i++) begin
        ent_state[i]  <= E_FREE;
        ent_line[i]   <= '0;
        ent_victim[i] <= '0;
        ent_wb[i]     <= 1'b0;
        ent_merges[i] <= '0;
      end
      mshr_count   <= '0;
      protocol_err <= 1'b0;
      fill_lock    <= 1'b0;
      fill_sel     <= '0;
    end else begin
      if (l2_resp_valid) begin
        if (ent_state[l2_resp_id] == E_ISSUED) ent_state[l2_resp_id] <= E_DONE;
        else protocol_err <= 1'b1;
      end
      if (rd_accept) ent_state[cur_id] <= E_ISSUED;
      if (wb_accept) ent_wb[cur_id] <= 1'b0;
      if (fill_hs) ent_state[fill_id] <= E_FREE;
      if (do_merge) ent_merges[hit_idx] <= ent_merges[hit_idx] + MERGE_W'(1);
      if (do_alloc) begin
        ent_state[free_idx]  <= E_PENDING;
        ent_line[free_idx]   <= miss_line;
        ent_victim[free_idx] <= miss_victim;
        ent_wb[free_idx]     <= miss_dirty;
        ent_merges[free_idx] <= '0;
      end
      if (do_alloc && !fill_hs) mshr_count <= mshr_count + CNT_ONE;
      else if (!do_alloc && fill_hs) mshr_count <= mshr_count - CNT_ONE;
      fill_lock <= fill_valid & ~fill_ready;
      fill_sel  <= fill_id;
    end
  end

  // Issue FSM: one L2 request in flight, request fields held while L2 stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iss_state    <= S_IDLE;
      cur_id       <= '0;
      hold_cnt     <= '0;
      wb_rd_en     <= 1'b0;
      l2_req_valid <= 1'b0;
      l2_req_rw    <= 1'b0;
      l2_req_line  <= '0;
      l2_req_id    <= '0;
    end else begin
      case (iss_state)
        S_IDLE: begin
          if (pend_found) begin
            cur_id    <= pend_idx;
            l2_req_id <= pend_idx;
            if (ent_wb[pend_idx]) begin
              iss_state <= S_WB_HOLD;
              hold_cnt  <= '0;
              wb_rd_en  <= 1'b1;
            end else begin
              iss_state    <= S_RD_REQ;
              l2_req_valid <= 1'b1;
              l2_req_rw    <= 1'b0;
              l2_req_line  <= ent_line[pend_idx];
            end
          end
        end
        S_WB_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            iss_state    <= S_WB_REQ;
            wb_rd_en     <= 1'b0;
            l2_req_valid <= 1'b1;
            l2_req_rw    <= 1'b1;
            l2_req_line  <= ent_victim[cur_id];
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_WB_REQ: begin
          if (!l2_stall) begin
            iss_state   <= S_RD_REQ;
            l2_req_rw   <= 1'b0;
            l2_req_line <= ent_line[cur_id];
          end
        end
        S_RD_REQ: begin
          if (!l2_stall) begin
            iss_state    <= S_IDLE;
            l2_req_valid <= 1'b0;
            l2_req_line  <= '0;
          end
        end
        default: iss_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mshr_miss_ctrl.sv
// Self-checking bench for l1_mshr_miss_ctrl: an entry-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_l1_mshr_miss_ctrl;
  localparam int LINE_W     = 26;
  localparam int N_MSHR     = 4;
  localparam int MERGE_W    = 2;
  localparam int L2_CLK_DIV = 1;
  localparam int ID_W       = 2;
  localparam int MERGE_MAX  = (1 << MERGE_W) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               miss_valid;
  logic [LINE_W-1:0]  miss_line;
  logic               miss_dirty;
  logic [LINE_W-1:0]  miss_victim;
  logic               miss_ready;
  logic               proc_stall;
  logic               wb_rd_en;
  logic               l2_req_valid;
  logic               l2_req_rw;
  logic [LINE_W-1:0]  l2_req_line;
  logic [ID_W-1:0]    l2_req_id;
  logic               l2_stall;
  logic               l2_resp_valid;
  logic [ID_W-1:0]    l2_resp_id;
  logic               fill_valid;
  logic [LINE_W-1:0]  fill_line;
  logic [ID_W-1:0]    fill_id;
  logic [MERGE_W-1:0] fill_merges;
  logic               fill_ready;
  logic [ID_W:0]      mshr_count;
  logic               protocol_err;

  l1_mshr_miss_ctrl #(
    .LINE_W(LINE_W), .N_MSHR(N_MSHR), .MERGE_W(MERGE_W), .L2_CLK_DIV(L2_CLK_DIV)
  ) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_line(miss_line), .miss_dirty(miss_dirty),
    .miss_victim(miss_victim), .miss_ready(miss_ready), .proc_stall(proc_stall),
    .wb_rd_en(wb_rd_en), .l2_req_valid(l2_req_valid), .l2_req_rw(l2_req_rw),
    .l2_req_line(l2_req_line), .l2_req_id(l2_req_id), .l2_stall(l2_stall),
    .l2_resp_valid(l2_resp_valid), .l2_resp_id(l2_resp_id),
    .fill_valid(fill_valid), .fill_line(fill_line), .fill_id(fill_id),
    .fill_merges(fill_merges), .fill_ready(fill_ready),
    .mshr_count(mshr_count), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entry status 0=free 1=waiting for L2 2=read sent 3=data back.
  int m_st   [N_MSHR];
  int m_line [N_MSHR];
  int m_vic  [N_MSHR];
  bit m_wb   [N_MSHR];
  int m_mrg  [N_MSHR];
  bit iss_busy;
  int iss_id;
  int iss_hold;
  bit iss_wbp;
  bit f_lock;
  int f_sel;
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < N_MSHR; i++) begin
      m_st[i] = 0; m_line[i] = 0; m_vic[i] = 0; m_wb[i] = 0; m_mrg[i] = 0;
    end
    iss_busy = 0; iss_id = 0; iss_hold = 0; iss_wbp = 0;
    f_lock = 0; f_sel = 0; m_err = 0;
  endfunction

  // Inputs change just after posedge, so negedge values are what the next edge samples.
  always @(negedge clock) begin
    int hit, fre, pend, done, cnt, fid, rline, rid;
    bit fvalid, fhs, e_ready, rv, rw, wbr, resp_ok;
    if (reset) begin
      model_reset();
      checkOutput("rst_miss_ready", miss_ready, 0);
      checkOutput("rst_proc_stall", proc_stall, miss_valid);
      checkOutput("rst_wb_rd_en", wb_rd_en, 0);
      checkOutput("rst_req_valid", l2_req_valid, 0);
      checkOutput("rst_fill_valid", fill_valid, 0);
      checkOutput("rst_count", mshr_count, 0);
      checkOutput("rst_err", protocol_err, 0);
    end else begin
      hit = -1; fre = -1; pend = -1; done = -1; cnt = 0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
        if (m_st[i] != 0 && m_line[i] == int'(miss_line)) hit = i;
        if (m_st[i] == 0) fre = i;
        if (m_st[i] == 1) pend = i;
        if (m_st[i] == 3) done = i;
        if (m_st[i] != 0) cnt++;
      end
      fvalid = f_lock || (done >= 0);
      fid    = f_lock ? f_sel : done;
      fhs    = fvalid && fill_ready;
      if (hit >= 0) e_ready = (m_mrg[hit] < MERGE_MAX) && !(fhs && fid == hit);
      else          e_ready = (fre >= 0);
      rv = 0; rw = 0; wbr = 0; rline = 0; rid = 0;
      if (iss_busy) begin
        if (iss_hold > 0) wbr = 1;
        else if (iss_wbp) begin rv = 1; rw = 1; rline = m_vic[iss_id]; rid = iss_id; end
        else begin rv = 1; rw = 0; rline = m_line[iss_id]; rid = iss_id; end
      end

      checkOutput("miss_ready", miss_ready, e_ready);
      checkOutput("proc_stall", proc_stall, miss_valid && !e_ready);
      checkOutput("wb_rd_en", wb_rd_en, wbr);
      checkOutput("l2_req_valid", l2_req_valid, rv);
      if (rv) begin
        checkOutput("l2_req_rw", l2_req_rw, rw);
        checkOutput("l2_req_line", l2_req_line, rline);
        checkOutput("l2_req_id", l2_req_id, rid);
      end
      checkOutput("fill_valid", fill_valid, fvalid);
      if (fvalid) begin
        checkOutput("fill_id", fill_id, fid);
        checkOutput("fill_line", fill_line, m_line[fid]);
        checkOutput("fill_merges", fill_merges, m_mrg[fid]);
      end
      checkOutput("mshr_count", mshr_count, cnt);
      checkOutput("protocol_err", protocol_err, m_err);

      resp_ok = l2_resp_valid && (m_st[l2_resp_id] == 2);
      if (l2_resp_valid && !resp_ok) m_err = 1;
      if (!iss_busy) begin
        if (pend >= 0) begin
          iss_busy = 1; iss_id = pend; iss_wbp = m_wb[pend];
          iss_hold = m_wb[pend] ? 2 * L2_CLK_DIV : 0;
        end
      end else if (iss_hold > 0) begin
        iss_hold--;
      end else if (!l2_stall) begin
        if (iss_wbp) iss_wbp = 0;
        else begin m_st[iss_id] = 2; iss_busy = 0; end
      end
      if (resp_ok) m_st[l2_resp_id] = 3;
      if (fhs) m_st[fid] = 0;
      if (miss_valid && e_ready) begin
        if (hit >= 0) m_mrg[hit]++;
        else begin
          m_st[fre] = 1; m_line[fre] = int'(miss_line); m_vic[fre] = int'(miss_victim);
          m_wb[fre] = miss_dirty; m_mrg[fre] = 0;
        end
      end
      f_lock = fvalid && !fill_ready;
      f_sel  = fid;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int line, input bit dirty, input int victim);
    miss_valid  = v;
    miss_line   = LINE_W'(line);
    miss_dirty  = dirty;
    miss_victim = LINE_W'(victim);
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    l2_stall = 0; l2_resp_valid = 0; l2_resp_id = '0; fill_ready = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    l2_stall = 0; l2_resp_valid = 0; l2_resp_id = '0; fill_ready = 0;
    @(negedge clock);
    checkOutput("init_miss_ready", miss_ready, 0);
    checkOutput("init_count", mshr_count, 0);

    // Clean miss, fill, refused merge during fill handshake, reuse next cycle.
    do_reset();
    applyStimulus(1, 'h10, 0, 0);
    @(negedge clock) checkOutput("t1_accept", miss_ready, 1);
    cyc(); applyStimulus(0, 0, 0, 0);
    cyc();
    @(negedge clock);
    checkOutput("t1_req_valid", l2_req_valid, 1);
    checkOutput("t1_req_rw", l2_req_rw, 0);
    checkOutput("t1_req_line", l2_req_line, 'h10);
    checkOutput("t1_req_id", l2_req_id, 0);
    cyc(); cyc(); cyc();
    l2_resp_valid = 1; l2_resp_id = 0;
    cyc();
    l2_resp_valid = 0; fill_ready = 1;
    applyStimulus(1, 'h10, 0, 0);
    @(negedge clock);
    checkOutput("t1_fill_valid", fill_valid, 1);
    checkOutput("t1_fill_line", fill_line, 'h10);
    checkOutput("t1_fill_merges", fill_merges, 0);
    checkOutput("t1_merge_refused", miss_ready, 0);
    cyc(); fill_ready = 0;
    @(negedge clock);
    checkOutput("t1_realloc", miss_ready, 1);
    checkOutput("t1_count_freed", mshr_count, 0);
    cyc(); applyStimulus(0, 0, 0, 0);
    @(negedge clock) checkOutput("t1_count_realloc", mshr_count, 1);

    // Dirty miss: two-cycle hold, write victim, then read line.
    do_reset();
    applyStimulus(1, 'h20, 1, 'h30);
    cyc(); applyStimulus(0, 0, 0, 0);
    cyc();
    @(negedge clock);
    checkOutput("t2_hold0", wb_rd_en, 1);
    checkOutput("t2_hold0_noreq", l2_req_valid, 0);
    cyc();
    @(negedge clock) checkOutput("t2_hold1", wb_rd_en, 1);
    cyc();
    @(negedge clock);
    checkOutput("t2_wr_rw", l2_req_rw, 1);
    checkOutput("t2_wr_line", l2_req_line, 'h30);
    checkOutput("t2_hold_end", wb_rd_en, 0);
    cyc();
    @(negedge clock);
    checkOutput("t2_rd_rw", l2_req_rw, 0);
    checkOutput("t2_rd_line", l2_req_line, 'h20);
    cyc(); l2_resp_valid = 1; l2_resp_id = 0;
    cyc(); l2_resp_valid = 0; fill_ready = 1;
    @(negedge clock) checkOutput("t2_fill_line", fill_line, 'h20);
    cyc(); fill_ready = 0;

    // Full MSHR stalls; entry freed by fill is reused one cycle later.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) cyc();
      applyStimulus(1, k, 0, 0);
    end
    cyc(); applyStimulus(1, 5, 0, 0);
    l2_resp_valid = 1; l2_resp_id = 0;
    @(negedge clock);
    checkOutput("t3_full_ready", miss_ready, 0);
    checkOutput("t3_full_stall", proc_stall, 1);
    cyc(); l2_resp_valid = 0; fill_ready = 1;
    @(negedge clock);
    checkOutput("t3_fill_id", fill_id, 0);
    checkOutput("t3_no_same_cycle", miss_ready, 0);
    cyc(); fill_ready = 0;
    @(negedge clock) checkOutput("t3_reuse", miss_ready, 1);
    cyc(); applyStimulus(0, 0, 0, 0);
    @(negedge clock) checkOutput("t3_count", mshr_count, 4);

    // Three merges saturate a 2-bit counter; the fourth stalls.
    do_reset();
    applyStimulus(1, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      @(negedge clock) checkOutput("t4_merge_ok", miss_ready, 1);
    end
    cyc();
    @(negedge clock) checkOutput("t4_saturated", miss_ready, 0);
    cyc(); applyStimulus(0, 0, 0, 0);
    l2_resp_valid = 1; l2_resp_id = 0;
    cyc(); l2_resp_valid = 0; fill_ready = 1;
    @(negedge clock) checkOutput("t4_fill_merges", fill_merges, 3);
    cyc(); fill_ready = 0;

    // Stalled request stays stable; out-of-order responses, fill choice held.
    do_reset();
    applyStimulus(1, 'h40, 0, 0);
    cyc(); applyStimulus(1, 'h41, 0, 0);
    cyc(); applyStimulus(1, 'h42, 0, 0);
    cyc(); applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      l2_stall = (k < 3);
      @(negedge clock);
      checkOutput("t5_stall_line", l2_req_line, 'h41);
      checkOutput("t5_stall_id", l2_req_id, 1);
    end
    cyc(); l2_stall = 0;
    cyc();
    cyc(); l2_resp_valid = 1; l2_resp_id = 2;
    cyc(); l2_resp_id = 0;
    @(negedge clock) checkOutput("t5_fill_first", fill_id, 2);
    cyc(); l2_resp_valid = 0; fill_ready = 1;
    @(negedge clock) checkOutput("t5_fill_held", fill_id, 2);
    cyc();
    @(negedge clock);
    checkOutput("t5_fill_second", fill_id, 0);
    checkOutput("t5_fill_second_line", fill_line, 'h40);
    cyc(); fill_ready = 0;

    // Protocol error is sticky; reset mid-writeback clears everything.
    do_reset();
    l2_resp_valid = 1; l2_resp_id = 3;
    cyc(); l2_resp_valid = 0;
    @(negedge clock) checkOutput("t6_err_set", protocol_err, 1);
    cyc(); applyStimulus(1, 'h50, 1, 'h60);
    @(negedge clock) checkOutput("t6_err_sticky", protocol_err, 1);
    cyc(); applyStimulus(0, 0, 0, 0);
    cyc();
    @(negedge clock) checkOutput("t6_in_hold", wb_rd_en, 1);
    cyc(); reset = 1;
    @(negedge clock);
    checkOutput("t6_rst_wb", wb_rd_en, 0);
    checkOutput("t6_rst_count", mshr_count, 0);
    checkOutput("t6_rst_err", protocol_err, 0);
    cyc(); reset = 0;
    l2_resp_valid = 1; l2_resp_id = 0;
    cyc(); l2_resp_valid = 0;
    @(negedge clock) checkOutput("t6_late_resp_err", protocol_err, 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
